// File: rtl/fifo_pkg.sv
// Shared FIFO constants and helpers: depth derivation, level/pointer widths,
// read-mode encoding. Imported by every FIFO variant.
package fifo_pkg;

    // Read-mode selector values for the FWFT parameter
    typedef enum logic {
        RD_STD  = 1'b0,
        RD_FWFT = 1'b1
    } rd_mode_e;

    // Defaults shared by FIFO variants that do not override them
    localparam int FIFO_DSIZE_DEF = 8;
    localparam int FIFO_ASIZE_DEF = 4;

    // Ceiling log2; clog2(1) = 0
    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

    // Number of storage entries for a given address width
    function automatic int fifo_depth(input int asize);
        return 1 << asize;
    endfunction

    // Level and pointer width: one extra bit so 0..DEPTH is representable
    // and pointers can distinguish wrap laps
    function automatic int fifo_lvl_w(input int asize);
        return asize + 1;
    endfunction

endpackage

// File: rtl/fifo_ram_2p.sv
// Two-port storage array: synchronous write, asynchronous read.
// No reset on contents.
module fifo_ram_2p
    import fifo_pkg::*;
#(
    parameter int DSIZE = 8,
    parameter int DEPTH = 16,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [DSIZE-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [DSIZE-1:0] o_rdata
);

    logic [DSIZE-1:0] r_mem [DEPTH];

    // Write port: data lands on the clock edge, readable from the next cycle
    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock parameterised FIFO with level count, almost-full/empty
// thresholds, sticky overflow/underflow and standard or FWFT read mode.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int DSIZE  = 8,
    parameter int ASIZE  = 4,
    parameter int AF_LVL = 12,
    parameter int AE_LVL = 2,
    parameter int FWFT   = 0
) (
    input  logic             i_clk,
    input  logic             i_rstn,
    input  logic             i_wreq,
    input  logic [DSIZE-1:0] i_wdata,
    output logic             o_full,
    output logic             o_afull,
    input  logic             i_rreq,
    output logic [DSIZE-1:0] o_rdata,
    output logic             o_rvalid,
    output logic             o_empty,
    output logic             o_aempty,
    output logic [ASIZE:0]   o_level,
    input  logic             i_clr_err,
    output logic             o_ovf,
    output logic             o_udf
);

    localparam int DEPTH = fifo_depth(ASIZE);
    localparam int LW    = fifo_lvl_w(ASIZE);

    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_AF   = LW'(AF_LVL);
    localparam logic [LW-1:0] LVL_AE   = LW'(AE_LVL);
    localparam logic [LW-1:0] ONE      = LW'(1);

    logic [LW-1:0]    r_wptr;
    logic [LW-1:0]    r_rptr;
    logic [LW-1:0]    r_level;
    logic             r_ovf;
    logic             r_udf;

    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic [DSIZE-1:0] w_ram_rdata;

    // Status flags decode the registered level only, so no request input
    // has a combinational path to them.
    assign w_empty  = (r_level == '0);
    assign w_full   = (r_level == LVL_FULL);

    assign o_empty  = w_empty;
    assign o_full   = w_full;
    assign o_afull  = (r_level >= LVL_AF);
    assign o_aempty = (r_level <= LVL_AE);
    assign o_level  = r_level;
    assign o_ovf    = r_ovf;
    assign o_udf    = r_udf;

    // A read frees the slot this cycle, so a full FIFO may still take a
    // write alongside an accepted read. An empty FIFO never reads, even if
    // a write arrives the same cycle: written data is not bypassed.
    assign w_rd_acc = i_rreq & ~w_empty;
    assign w_wr_acc = i_wreq & (~w_full | w_rd_acc);

    fifo_ram_2p #(
        .DSIZE (DSIZE),
        .DEPTH (DEPTH),
        .AW    (ASIZE)
    ) u_ram (
        .i_clk   (i_clk),
        .i_we    (w_wr_acc),
        .i_waddr (r_wptr[ASIZE-1:0]),
        .i_wdata (i_wdata),
        .i_raddr (r_rptr[ASIZE-1:0]),
        .o_rdata (w_ram_rdata)
    );

    // Write pointer advances on every accepted write
    always_ff @(posedge i_clk) begin
        if (!i_rstn)       r_wptr <= '0;
        else if (w_wr_acc) r_wptr <= r_wptr + ONE;
    end

    // Read pointer advances on every accepted read
    always_ff @(posedge i_clk) begin
        if (!i_rstn)       r_rptr <= '0;
        else if (w_rd_acc) r_rptr <= r_rptr + ONE;
    end

    // Level tracks accepted writes minus accepted reads
    always_ff @(posedge i_clk) begin
        if (!i_rstn)                      r_level <= '0;
        else if (w_wr_acc && !w_rd_acc)   r_level <= r_level + ONE;
        else if (!w_wr_acc && w_rd_acc)   r_level <= r_level - ONE;
    end

    // Sticky error flags; a new error in the clear cycle keeps the flag set
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            r_ovf <= 1'b0;
            r_udf <= 1'b0;
        end else begin
            r_ovf <= (r_ovf & ~i_clr_err) | (i_wreq & ~w_wr_acc);
            r_udf <= (r_udf & ~i_clr_err) | (i_rreq & w_empty);
        end
    end

    // Pointer distance must always agree with the level counter
    always_ff @(posedge i_clk) begin
        if (i_rstn) assert ((r_wptr - r_rptr) == r_level);
    end

    generate
        if (FWFT == int'(RD_STD)) begin : g_std
            logic [DSIZE-1:0] r_rdata;
            logic             r_rvalid;

            // Registered read: capture head word on accept, pulse rvalid
            always_ff @(posedge i_clk) begin
                if (!i_rstn) begin
                    r_rdata  <= '0;
                    r_rvalid <= 1'b0;
                end else begin
                    r_rvalid <= w_rd_acc;
                    if (w_rd_acc) r_rdata <= w_ram_rdata;
                end
            end

            assign o_rdata  = r_rdata;
            assign o_rvalid = r_rvalid;
        end else begin : g_fwft
            // Head word is presented continuously; rreq only pops it
            assign o_rdata  = w_ram_rdata;
            assign o_rvalid = ~w_empty;
        end
    endgenerate

endmodule
